// File: rtl/dma_pkg.sv
// Shared types and constants for the mem_copy_dma word-copy engine.
// Optional checksum output is enabled by defining MEM_COPY_DMA_CHECKSUM_EN.
package dma_pkg;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 32;
    localparam int LEN_W_DEFAULT  = 9;
    localparam int WORD_STRIDE    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable byte pointer that advances by one word and wraps modulo 2^ADDR_W.
// Used by mem_copy_dma (macro MEM_COPY_DMA_CHECKSUM_EN has no effect here).
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_ptr
);

    logic [ADDR_W-1:0] r_ptr;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_addr;
        end else if (i_inc) begin
            // natural overflow gives the 0xFFFC -> 0x0000 wrap
            r_ptr <= r_ptr + ADDR_W'(WORD_STRIDE);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/mem_copy_dma.sv
// Word-copy DMA initiator for the single-cycle MIPS data-memory port.
// Define MEM_COPY_DMA_CHECKSUM_EN to add a running sum of words read.
//
// state | meaning
// IDLE  | port released, waiting for start
// READ  | memRead at src pointer, data_reg captures read data
// WRITE | memWrite of data_reg at dst pointer, pointers advance
// DONE  | one-cycle completion pulse, err valid
module mem_copy_dma
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    dma_state_t        r_state;
    dma_state_t        w_next;
    logic              r_err;
    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_remaining;

    logic              w_start_idle;
    logic              w_misaligned;
    logic              w_load;
    logic              w_inc;
    logic [ADDR_W-1:0] w_src_ptr;
    logic [ADDR_W-1:0] w_dst_ptr;

    assign w_start_idle = (r_state == IDLE) && start;
    assign w_misaligned = !word_aligned(src_addr[1:0]) || !word_aligned(dst_addr[1:0]);
    assign w_load       = w_start_idle && !w_misaligned && (len != '0);
    assign w_inc        = (r_state == WRITE);

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clock       (clock),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_addr (src_addr),
        .i_inc       (w_inc),
        .o_ptr       (w_src_ptr)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_dst_gen (
        .clock       (clock),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_addr (dst_addr),
        .i_inc       (w_inc),
        .o_ptr       (w_dst_ptr)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    // rejected and zero-length requests skip straight to DONE
                    w_next = w_load ? READ : DONE;
                end
            end
            READ:    w_next = WRITE;
            WRITE:   w_next = (r_remaining == LEN_W'(1)) ? DONE : READ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy           = (r_state != IDLE);
        done           = (r_state == DONE);
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (r_state)
            READ: begin
                mem_read = 1'b1;
                mem_addr = w_src_ptr;
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_addr       = w_dst_ptr;
                mem_write_data = r_data;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_err       <= 1'b0;
            r_data      <= '0;
            r_remaining <= '0;
        end else begin
            if (w_start_idle) begin
                r_err <= w_misaligned;
            end
            if (r_state == READ) begin
                r_data <= mem_read_data;
            end
            if (w_load) begin
                r_remaining <= len;
            end else if (r_state == WRITE) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    assign err = r_err;

`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (w_start_idle) begin
            r_checksum <= '0;
        end else if (r_state == READ) begin
            r_checksum <= r_checksum + mem_read_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma with a 256-word behavioural data memory.
// Checksum checks are compiled in when MEM_COPY_DMA_CHECKSUM_EN is defined.
module tb_mem_copy_dma;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;
`ifdef MEM_COPY_DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clock = ~clock;

    mem_copy_dma dut (
        .clock          (clock),
        .rst            (rst),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    assign mem_read_data = mem[mem_addr[9:2]];

    always @(posedge clock) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (mem_write) mem[mem_addr[9:2]] <= mem_write_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // per-run observations
    int          busy_cnt, wr_cnt, rd_cnt, both_cnt, done_cnt, done_k, post_cnt;
    logic        err_done, err_after;
    logic [15:0] rd_q[$];
    logic [31:0] snap [256];
    logic [31:0] expm [256];

    task automatic take_snapshot();
        for (int i = 0; i < 256; i++) snap[i] = mem[i];
    endtask

    // forward word-by-word copy, so overlapping ranges behave like the engine
    task automatic build_expected(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [7:0] si, di;
        for (int i = 0; i < 256; i++) expm[i] = snap[i];
        si = s[9:2];
        di = d[9:2];
        for (int k = 0; k < n; k++) begin
            expm[di] = expm[si];
            si = si + 8'd1;
            di = di + 8'd1;
        end
    endtask

    function automatic int mem_diffs();
        int c = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== expm[i]) c++;
        return c;
    endfunction

    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [8:0] n,
                            input int extra_k);
        rd_q.delete();
        busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; both_cnt = 0;
        done_cnt = 0; done_k = 0; post_cnt = 0;
        err_done = 1'bx;
        @(posedge clock); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 1; k <= 1200; k++) begin
            start = (extra_k != 0) && ((k == extra_k) || done);
            if (busy) busy_cnt++;
            if (mem_write) wr_cnt++;
            if (mem_read) begin
                rd_cnt++;
                rd_q.push_back(mem_addr);
            end
            if (mem_read && mem_write) both_cnt++;
            if (done) begin
                done_cnt++;
                done_k   = k;
                err_done = err;
            end
            @(posedge clock); #1;
            if (done_k != 0) break;
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (busy || done) post_cnt++;
            @(posedge clock); #1;
        end
        err_after = err;
    endtask

    typedef struct {
        string       name;
        logic [15:0] src;
        logic [15:0] dst;
        logic [8:0]  len;
        logic        exp_err;
        int          exp_busy;
        int          exp_wr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{"copy4",   16'h0010, 16'h0080, 9'd4, 1'b0, 9,  4};
        vecs[1] = '{"len0",    16'h0100, 16'h0200, 9'd0, 1'b0, 1,  0};
        vecs[2] = '{"src_mis", 16'h0012, 16'h0080, 9'd4, 1'b1, 1,  0};
        vecs[3] = '{"dst_mis", 16'h0020, 16'h0042, 9'd2, 1'b1, 1,  0};
        vecs[4] = '{"copy1",   16'h0100, 16'h0300, 9'd1, 1'b0, 3,  1};
        vecs[5] = '{"copy5",   16'h0200, 16'h0240, 9'd5, 1'b0, 11, 5};
        vecs[6] = '{"overlap", 16'h0300, 16'h0304, 9'd3, 1'b0, 7,  3};

        rst = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        #2;
        chk("reset_ctl", {29'd0, busy, done, err}, 32'd0);
        chk("reset_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("reset_addr", {16'd0, mem_addr}, 32'd0);
        chk("reset_wdata", mem_write_data, 32'd0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        chk("reset_checksum", checksum, 32'd0);
`endif

        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            pl_en  = 1'b1;
            pl_idx = 8'(i);
            case (i)
                0:       pl_data = 32'h0000_0002;
                4:       pl_data = 32'h0000_0011;
                5:       pl_data = 32'h0000_0022;
                6:       pl_data = 32'h0000_0033;
                7:       pl_data = 32'h0000_0044;
                255:     pl_data = 32'hFFFF_FFFF;
                default: pl_data = 32'hC0DE_0000 + 32'(i);
            endcase
        end
        @(negedge clock);
        pl_en = 1'b0;
        rst   = 1'b1;

        for (int v = 0; v < 7; v++) begin
            take_snapshot();
            build_expected(vecs[v].src, vecs[v].dst, vecs[v].exp_err ? 0 : int'(vecs[v].len));
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].len, 0);
            chk({vecs[v].name, "_busy"}, busy_cnt, vecs[v].exp_busy);
            chk({vecs[v].name, "_done_cycle"}, done_k, vecs[v].exp_busy);
            chk({vecs[v].name, "_done_count"}, done_cnt, 1);
            chk({vecs[v].name, "_writes"}, wr_cnt, vecs[v].exp_wr);
            chk({vecs[v].name, "_reads"}, rd_cnt, vecs[v].exp_wr);
            chk({vecs[v].name, "_rw_overlap"}, both_cnt, 0);
            chk({vecs[v].name, "_err"}, {31'd0, err_done}, {31'd0, vecs[v].exp_err});
            chk({vecs[v].name, "_err_hold"}, {31'd0, err_after}, {31'd0, vecs[v].exp_err});
            chk({vecs[v].name, "_idle_after"}, post_cnt, 0);
            chk({vecs[v].name, "_mem_diffs"}, mem_diffs(), 0);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
            if (v == 0) chk("copy4_checksum", checksum, 32'h0000_00AA);
`endif
        end

        // rejected request, then a valid start must clear err on acceptance
        run_copy(16'h0012, 16'h0080, 9'd1, 0);
        chk("rej_err", {31'd0, err_after}, 32'd1);
        take_snapshot();
        build_expected(16'h0010, 16'h0090, 1);
        @(posedge clock); #1;
        start = 1'b1; src_addr = 16'h0010; dst_addr = 16'h0090; len = 9'd1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("clear_err_t1", {31'd0, err}, 32'd0);
        chk("clear_read_t1", {15'd0, mem_read, mem_addr}, {15'd0, 1'b1, 16'h0010});
        for (int k = 0; k < 50 && busy; k++) begin
            @(posedge clock); #1;
        end
        chk("clear_mem_diffs", mem_diffs(), 0);

        // start pulsed mid-copy and during DONE must be ignored
        take_snapshot();
        build_expected(16'h0140, 16'h0180, 3);
        run_copy(16'h0140, 16'h0180, 9'd3, 3);
        chk("restart_writes", wr_cnt, 3);
        chk("restart_done_count", done_cnt, 1);
        chk("restart_busy", busy_cnt, 7);
        chk("restart_idle_after", post_cnt, 0);
        chk("restart_mem_diffs", mem_diffs(), 0);

        // reset during the second WRITE of an 8-word copy
        take_snapshot();
        @(posedge clock); #1;
        start = 1'b1; src_addr = 16'h0280; dst_addr = 16'h02C0; len = 9'd8;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("abort_in_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_ctl", {29'd0, busy, done, err}, 32'd0);
        chk("abort_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("abort_addr_wdata", {16'd0, mem_addr} | mem_write_data, 32'd0);
        @(posedge clock); #1;
        rst = 1'b1;
        chk("abort_word0", mem[8'hB0], snap[8'hA0]);
        chk("abort_word1", mem[8'hB1], snap[8'hB1]);
        take_snapshot();
        build_expected(16'h0280, 16'h0380, 2);
        run_copy(16'h0280, 16'h0380, 9'd2, 0);
        chk("after_reset_busy", busy_cnt, 5);
        chk("after_reset_mem_diffs", mem_diffs(), 0);

        // source pointer wraps from 0xFFFC to 0x0000
        run_copy(16'hFFFC, 16'h0040, 9'd2, 0);
        chk("wrap_reads", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            chk("wrap_rd0_addr", {16'd0, rd_q[0]}, 32'h0000_FFFC);
            chk("wrap_rd1_addr", {16'd0, rd_q[1]}, 32'h0000_0000);
        end
        chk("wrap_word0", mem[16], 32'hFFFF_FFFF);
        chk("wrap_word1", mem[17], 32'h0000_0002);
`ifdef MEM_COPY_DMA_CHECKSUM_EN
        chk("wrap_checksum", checksum, 32'h0000_0001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
